// File: rtl/calculator_core_param.sv
// Calculator control path: operand/opcode capture on button edges, registered
// ALU with flags, and one sequential double-dabble converter per value.

// Sequential binary-to-BCD converter; loads one cycle after a write strobe.
module calculator_core_param_bcd #(
  parameter int WIDTH  = 8,
  parameter int DIGITS = 3
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  load,
  input  logic [WIDTH-1:0]      value,
  output logic [4*DIGITS-1:0]   bcd,
  output logic                  busy
);
  localparam int CW = $clog2(WIDTH + 1);

  logic [WIDTH-1:0]    shift_r;
  logic [4*DIGITS-1:0] work_r;
  logic [4*DIGITS-1:0] bcd_r;
  logic [4*DIGITS-1:0] step_s;
  logic [CW-1:0]       cnt_r;
  logic                busy_r;

  // One double-dabble iteration: add 3 to every digit >= 5, then shift a bit in.
  function automatic logic [4*DIGITS-1:0] dd_step(input logic [4*DIGITS-1:0] digits,
                                                  input logic bit_in);
    logic [4*DIGITS-1:0] adj;
    adj = digits;
    for (int i = 0; i < DIGITS; i++) begin
      if (adj[4*i +: 4] >= 4'd5) begin
        adj[4*i +: 4] = adj[4*i +: 4] + 4'd3;
      end else begin
        adj[4*i +: 4] = adj[4*i +: 4];
      end
    end
    return {adj[4*DIGITS-2:0], bit_in};
  endfunction

  assign step_s = dd_step(work_r, shift_r[WIDTH-1]);

  // Load on strobe (restarting any conversion), else step until WIDTH bits consumed.
  always_ff @(posedge clock) begin
    if (reset) begin
      shift_r <= '0;
      work_r  <= '0;
      bcd_r   <= '0;
      cnt_r   <= '0;
      busy_r  <= 1'b0;
    end else if (load) begin
      shift_r <= value;
      work_r  <= '0;
      cnt_r   <= CW'(WIDTH);
      busy_r  <= 1'b1;
    end else if (busy_r) begin
      work_r  <= step_s;
      shift_r <= {shift_r[WIDTH-2:0], 1'b0};
      cnt_r   <= cnt_r - CW'(1);
      if (cnt_r == CW'(1)) begin
        busy_r <= 1'b0;
        bcd_r  <= step_s;
      end
    end
  end

  assign bcd  = bcd_r;
  assign busy = busy_r;
endmodule

module calculator_core_param #(
  parameter int WIDTH  = 8,
  parameter int DIGITS = 3,
  parameter int OPW    = 4
) (
  input  logic                  clock,
  input  logic                  Reset,
  input  logic [WIDTH+OPW-1:0]  Switchs,
  input  logic                  Enter,
  input  logic                  Clear,
  output logic [WIDTH-1:0]      A,
  output logic [WIDTH-1:0]      B,
  output logic [WIDTH-1:0]      Result,
  output logic [OPW-1:0]        Operation,
  output logic                  Zero,
  output logic                  CarryOut,
  output logic                  Overflow,
  output logic                  Error,
  output logic [3:0]            Leds,
  output logic [4*DIGITS-1:0]   BcdA,
  output logic [4*DIGITS-1:0]   BcdB,
  output logic [4*DIGITS-1:0]   BcdResult,
  output logic                  BcdBusy
);
  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    WITH_A  = 3'd1,
    WITH_B  = 3'd2,
    COMPUTE = 3'd3,
    RESULT  = 3'd4,
    ERROR   = 3'd5
  } state_t;

  localparam logic [OPW-1:0] OP_ADD = OPW'(0);
  localparam logic [OPW-1:0] OP_SUB = OPW'(1);
  localparam logic [OPW-1:0] OP_AND = OPW'(2);
  localparam logic [OPW-1:0] OP_OR  = OPW'(3);
  localparam logic [OPW-1:0] OP_XOR = OPW'(4);
  localparam logic [OPW-1:0] OP_NOT = OPW'(5);
  localparam logic [OPW-1:0] OP_SHL = OPW'(6);
  localparam logic [OPW-1:0] OP_SHR = OPW'(7);
  localparam logic [OPW-1:0] OP_MUL = OPW'(8);

  state_t           state_r;
  logic [WIDTH-1:0] a_r, b_r, res_r;
  logic [OPW-1:0]   op_r;
  logic             zero_r, carry_r, ovf_r, error_r, clr_pend_r;
  logic [3:0]       leds_r;
  logic             enter_d_r, clear_d_r;
  logic             wr_a_r, wr_b_r, wr_res_r;
  logic             enter_p_s, clear_p_s;
  logic [WIDTH-1:0] operand_s;
  logic [OPW-1:0]   opcode_s;
  logic [WIDTH-1:0] alu_res_s;
  logic             alu_c_s, alu_v_s, alu_valid_s;
  logic [WIDTH:0]   sum_s;
  logic [2*WIDTH-1:0] prod_s;
  logic             busy_a_s, busy_b_s, busy_r_s;

  assign enter_p_s = Enter & ~enter_d_r;
  assign clear_p_s = Clear & ~clear_d_r;
  assign operand_s = Switchs[WIDTH-1:0];
  assign opcode_s  = Switchs[WIDTH+OPW-1:WIDTH];

  function automatic logic [3:0] leds_of(input state_t s);
    case (s)
      IDLE:    leds_of = 4'b0001;
      WITH_A:  leds_of = 4'b0011;
      WITH_B:  leds_of = 4'b0111;
      COMPUTE: leds_of = 4'b0111;
      RESULT:  leds_of = 4'b1111;
      ERROR:   leds_of = 4'b1001;
      default: leds_of = 4'b0001;
    endcase
  endfunction

  // ALU on the captured operands and opcode; flags follow the opcode table.
  always_comb begin
    sum_s       = {1'b0, a_r} + {1'b0, b_r};
    prod_s      = {{WIDTH{1'b0}}, a_r} * {{WIDTH{1'b0}}, b_r};
    alu_res_s   = '0;
    alu_c_s     = 1'b0;
    alu_v_s     = 1'b0;
    alu_valid_s = 1'b1;
    case (op_r)
      OP_ADD: begin
        alu_res_s = sum_s[WIDTH-1:0];
        alu_c_s   = sum_s[WIDTH];
        alu_v_s   = (a_r[WIDTH-1] == b_r[WIDTH-1]) && (sum_s[WIDTH-1] != a_r[WIDTH-1]);
      end
      OP_SUB: begin
        alu_res_s = a_r - b_r;
        alu_c_s   = (a_r < b_r);
        alu_v_s   = (a_r[WIDTH-1] != b_r[WIDTH-1]) && (alu_res_s[WIDTH-1] != a_r[WIDTH-1]);
      end
      OP_AND: alu_res_s = a_r & b_r;
      OP_OR:  alu_res_s = a_r | b_r;
      OP_XOR: alu_res_s = a_r ^ b_r;
      OP_NOT: alu_res_s = ~a_r;
      OP_SHL: begin
        alu_res_s = {a_r[WIDTH-2:0], 1'b0};
        alu_c_s   = a_r[WIDTH-1];
      end
      OP_SHR: begin
        alu_res_s = {1'b0, a_r[WIDTH-1:1]};
        alu_c_s   = a_r[0];
      end
      OP_MUL: begin
        alu_res_s = prod_s[WIDTH-1:0];
        alu_v_s   = |prod_s[2*WIDTH-1:WIDTH];
      end
      default: alu_valid_s = 1'b0;
    endcase
  end

  // Control FSM: button edges, data capture, compute, chaining and clears.
  always_ff @(posedge clock) begin
    if (Reset) begin
      state_r    <= IDLE;
      a_r        <= '0;
      b_r        <= '0;
      res_r      <= '0;
      op_r       <= '0;
      zero_r     <= 1'b0;
      carry_r    <= 1'b0;
      ovf_r      <= 1'b0;
      error_r    <= 1'b0;
      leds_r     <= 4'b0001;
      clr_pend_r <= 1'b0;
      enter_d_r  <= 1'b1;
      clear_d_r  <= 1'b1;
      wr_a_r     <= 1'b0;
      wr_b_r     <= 1'b0;
      wr_res_r   <= 1'b0;
    end else begin
      enter_d_r  <= Enter;
      clear_d_r  <= Clear;
      clr_pend_r <= 1'b0;
      wr_a_r     <= 1'b0;
      wr_b_r     <= 1'b0;
      wr_res_r   <= 1'b0;
      case (state_r)
        IDLE: begin
          if (enter_p_s && !clear_p_s) begin
            a_r     <= operand_s;
            wr_a_r  <= 1'b1;
            state_r <= WITH_A;
            leds_r  <= leds_of(WITH_A);
          end
        end
        WITH_A: begin
          if (clear_p_s) begin
            a_r     <= '0;
            wr_a_r  <= 1'b1;
            state_r <= IDLE;
            leds_r  <= leds_of(IDLE);
          end else if (enter_p_s) begin
            b_r     <= operand_s;
            wr_b_r  <= 1'b1;
            state_r <= WITH_B;
            leds_r  <= leds_of(WITH_B);
          end
        end
        WITH_B: begin
          if (clear_p_s) begin
            a_r     <= '0;
            b_r     <= '0;
            wr_a_r  <= 1'b1;
            wr_b_r  <= 1'b1;
            state_r <= IDLE;
            leds_r  <= leds_of(IDLE);
          end else if (enter_p_s) begin
            op_r    <= opcode_s;
            state_r <= COMPUTE;
            leds_r  <= leds_of(COMPUTE);
          end
        end
        COMPUTE: begin
          // A Clear seen here is deferred one cycle so the result still lands.
          clr_pend_r <= clear_p_s;
          wr_res_r   <= 1'b1;
          res_r      <= alu_valid_s ? alu_res_s : '0;
          carry_r    <= alu_valid_s & alu_c_s;
          ovf_r      <= alu_valid_s & alu_v_s;
          zero_r     <= alu_valid_s & (alu_res_s == '0);
          error_r    <= ~alu_valid_s;
          state_r    <= alu_valid_s ? RESULT : ERROR;
          leds_r     <= alu_valid_s ? leds_of(RESULT) : leds_of(ERROR);
        end
        RESULT, ERROR: begin
          if (clear_p_s || clr_pend_r) begin
            a_r      <= '0;
            b_r      <= '0;
            res_r    <= '0;
            op_r     <= '0;
            zero_r   <= 1'b0;
            carry_r  <= 1'b0;
            ovf_r    <= 1'b0;
            error_r  <= 1'b0;
            wr_a_r   <= 1'b1;
            wr_b_r   <= 1'b1;
            wr_res_r <= 1'b1;
            state_r  <= IDLE;
            leds_r   <= leds_of(IDLE);
          end else if (enter_p_s && (state_r == RESULT)) begin
            a_r      <= res_r;
            b_r      <= '0;
            res_r    <= '0;
            op_r     <= '0;
            zero_r   <= 1'b0;
            carry_r  <= 1'b0;
            ovf_r    <= 1'b0;
            wr_a_r   <= 1'b1;
            wr_b_r   <= 1'b1;
            wr_res_r <= 1'b1;
            state_r  <= WITH_A;
            leds_r   <= leds_of(WITH_A);
          end
        end
        default: begin
          state_r <= IDLE;
          leds_r  <= leds_of(IDLE);
          error_r <= 1'b0;
        end
      endcase
    end
  end

  calculator_core_param_bcd #(.WIDTH(WIDTH), .DIGITS(DIGITS)) u_bcd_a (
    .clock(clock), .reset(Reset), .load(wr_a_r), .value(a_r), .bcd(BcdA), .busy(busy_a_s)
  );
  calculator_core_param_bcd #(.WIDTH(WIDTH), .DIGITS(DIGITS)) u_bcd_b (
    .clock(clock), .reset(Reset), .load(wr_b_r), .value(b_r), .bcd(BcdB), .busy(busy_b_s)
  );
  calculator_core_param_bcd #(.WIDTH(WIDTH), .DIGITS(DIGITS)) u_bcd_r (
    .clock(clock), .reset(Reset), .load(wr_res_r), .value(res_r), .bcd(BcdResult), .busy(busy_r_s)
  );

  assign A         = a_r;
  assign B         = b_r;
  assign Result    = res_r;
  assign Operation = op_r;
  assign Zero      = zero_r;
  assign CarryOut  = carry_r;
  assign Overflow  = ovf_r;
  assign Error     = error_r;
  assign Leds      = leds_r;
  assign BcdBusy   = busy_a_s | busy_b_s | busy_r_s;
endmodule

// File: tb/tb_calculator_core_param.sv
// Directed self-checking bench for calculator_core_param (WIDTH=8, DIGITS=3).
module tb_calculator_core_param;
  logic        clock = 1'b0;
  logic        Reset;
  logic [11:0] Switchs;
  logic        Enter, Clear;
  logic [7:0]  A, B, Result;
  logic [3:0]  Operation, Leds;
  logic        Zero, CarryOut, Overflow, Error, BcdBusy;
  logic [11:0] BcdA, BcdB, BcdResult;

  int n_checks = 0;
  int n_fail   = 0;

  calculator_core_param #(.WIDTH(8), .DIGITS(3), .OPW(4)) dut (
    .clock(clock), .Reset(Reset), .Switchs(Switchs), .Enter(Enter), .Clear(Clear),
    .A(A), .B(B), .Result(Result), .Operation(Operation),
    .Zero(Zero), .CarryOut(CarryOut), .Overflow(Overflow), .Error(Error),
    .Leds(Leds), .BcdA(BcdA), .BcdB(BcdB), .BcdResult(BcdResult), .BcdBusy(BcdBusy)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clock);
      #1;
    end
  endtask

  task automatic press(input logic [11:0] sw);
    Switchs = sw;
    Enter   = 1'b1;
    tick(1);
    Enter   = 1'b0;
    tick(1);
  endtask

  task automatic pulse_clear();
    Clear = 1'b1;
    tick(1);
    Clear = 1'b0;
    tick(1);
  endtask

  initial begin
    Reset = 1'b1; Enter = 1'b0; Clear = 1'b0; Switchs = 12'd0;
    tick(3);
    Reset = 1'b0;
    tick(1);
    check("rst_leds", Leds, 32'h1);
    check("rst_a", A, 32'h0);
    check("rst_result", Result, 32'h0);
    check("rst_error", Error, 32'h0);
    check("rst_busy", BcdBusy, 32'h0);
    check("rst_bcdr", BcdResult, 32'h0);

    // 200 + 100 = 300 -> 44 with carry
    press({4'd0, 8'd200});
    check("t1_a", A, 32'd200);
    check("t1_leds_a", Leds, 32'h3);
    press({4'd0, 8'd100});
    check("t1_b", B, 32'd100);
    check("t1_leds_b", Leds, 32'h7);
    press({4'd0, 8'd0});
    check("t1_res", Result, 32'd44);
    check("t1_c", CarryOut, 32'h1);
    check("t1_v", Overflow, 32'h0);
    check("t1_z", Zero, 32'h0);
    check("t1_leds", Leds, 32'hF);
    tick(8);
    check("t1_bcd_hold", BcdResult, 32'h000);
    check("t1_busy_hold", BcdBusy, 32'h1);
    tick(1);
    check("t1_bcdr", BcdResult, 32'h044);
    check("t1_bcda", BcdA, 32'h200);
    check("t1_bcdb", BcdB, 32'h100);
    check("t1_busy_done", BcdBusy, 32'h0);

    // 5 - 7 = 254 with borrow, then chain
    pulse_clear();
    check("t2_clr_leds", Leds, 32'h1);
    press({4'd0, 8'd5});
    press({4'd0, 8'd7});
    press({4'd1, 8'd0});
    check("t2_res", Result, 32'd254);
    check("t2_c", CarryOut, 32'h1);
    check("t2_v", Overflow, 32'h0);
    tick(9);
    check("t2_bcdr", BcdResult, 32'h254);
    press({4'd0, 8'd0});
    check("t2_chain_a", A, 32'd254);
    check("t2_chain_b", B, 32'd0);
    check("t2_chain_res", Result, 32'd0);
    check("t2_chain_c", CarryOut, 32'h0);
    check("t2_chain_leds", Leds, 32'h3);
    tick(8);
    check("t2_chain_bcda", BcdA, 32'h254);
    check("t2_chain_bcdr", BcdResult, 32'h000);
    pulse_clear();

    // 20 * 13 = 260 -> 4 with overflow
    press({4'd0, 8'd20});
    press({4'd0, 8'd13});
    press({4'd8, 8'd0});
    check("t3_mul_res", Result, 32'd4);
    check("t3_mul_v", Overflow, 32'h1);
    check("t3_mul_c", CarryOut, 32'h0);
    pulse_clear();

    // 128 + 128 = 256 -> 0, Z, C, V
    press({4'd0, 8'd128});
    press({4'd0, 8'd128});
    press({4'd0, 8'd0});
    check("t3_add_res", Result, 32'd0);
    check("t3_add_z", Zero, 32'h1);
    check("t3_add_c", CarryOut, 32'h1);
    check("t3_add_v", Overflow, 32'h1);
    pulse_clear();

    // Invalid opcode 12 -> ERROR
    press({4'd0, 8'd1});
    press({4'd0, 8'd2});
    press({4'd12, 8'd0});
    check("t4_err", Error, 32'h1);
    check("t4_leds", Leds, 32'h9);
    check("t4_res", Result, 32'h0);
    check("t4_z", Zero, 32'h0);
    for (int i = 0; i < 5; i++) press({4'd3, 8'd77});
    check("t4_err_hold", Error, 32'h1);
    check("t4_leds_hold", Leds, 32'h9);
    check("t4_a_hold", A, 32'd1);
    check("t4_b_hold", B, 32'd2);
    pulse_clear();
    check("t4_clr_leds", Leds, 32'h1);
    check("t4_clr_err", Error, 32'h0);
    check("t4_clr_a", A, 32'h0);
    check("t4_clr_b", B, 32'h0);
    check("t4_clr_op", Operation, 32'h0);
    tick(10);
    check("t4_clr_bcda", BcdA, 32'h0);
    check("t4_clr_bcdb", BcdB, 32'h0);
    check("t4_clr_busy", BcdBusy, 32'h0);

    // Enter held 10 cycles -> one step only
    Switchs = {4'd0, 8'd9};
    Enter = 1'b1;
    tick(10);
    Enter = 1'b0;
    tick(1);
    check("t5_hold_leds", Leds, 32'h3);
    check("t5_hold_a", A, 32'd9);
    pulse_clear();
    // Enter held through reset release -> no step
    Enter = 1'b1;
    Reset = 1'b1;
    tick(2);
    Reset = 1'b0;
    tick(3);
    Enter = 1'b0;
    tick(1);
    check("t5_rst_leds", Leds, 32'h1);
    check("t5_rst_a", A, 32'h0);

    // Enter and Clear together in WITH_B -> Clear wins
    press({4'd0, 8'd3});
    press({4'd0, 8'd4});
    Enter = 1'b1; Clear = 1'b1;
    tick(1);
    Enter = 1'b0; Clear = 1'b0;
    tick(1);
    check("t6_leds", Leds, 32'h1);
    check("t6_a", A, 32'h0);
    check("t6_b", B, 32'h0);

    // Clear during COMPUTE -> deferred one cycle
    press({4'd0, 8'd3});
    press({4'd0, 8'd4});
    Switchs = {4'd0, 8'd0};
    Enter = 1'b1;
    tick(1);
    Enter = 1'b0; Clear = 1'b1;
    tick(1);
    check("t7_res", Result, 32'd7);
    check("t7_leds_res", Leds, 32'hF);
    Clear = 1'b0;
    tick(1);
    check("t7_leds_idle", Leds, 32'h1);
    check("t7_res_clr", Result, 32'h0);

    // Reset mid-conversion
    tick(10);
    press({4'd0, 8'd200});
    tick(8);
    check("t8_bcda", BcdA, 32'h200);
    pulse_clear();
    tick(3);
    check("t8_busy", BcdBusy, 32'h1);
    check("t8_bcda_hold", BcdA, 32'h200);
    Reset = 1'b1;
    tick(1);
    Reset = 1'b0;
    check("t8_rst_bcda", BcdA, 32'h0);
    check("t8_rst_bcdb", BcdB, 32'h0);
    check("t8_rst_bcdr", BcdResult, 32'h0);
    check("t8_rst_busy", BcdBusy, 32'h0);
    check("t8_rst_leds", Leds, 32'h1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/calculator_core_param.md
# calculator_core_param

Parametrised successor of the calculator control path. The block captures two WIDTH-bit operands and an opcode from the switch bank, sequencing on debounced Enter/Clear button edges. It computes a registered ALU result with flags and converts A, B and Result to packed BCD with sequential double-dabble converters. It sits between the synchronised board inputs and the seven-segment decoders and adds the following over the previous generation:
- edge-detected buttons
- an ERROR state
- multi-cycle BCD
- result chaining

## Interface
Parameters:
- WIDTH, 8, operand/result width (≥2)
- DIGITS, 3, BCD digits per value; must satisfy 10^DIGITS > 2^WIDTH
- OPW, 4, opcode width

Ports:
- clock  in  1  rising-edge clock; the block uses one clock
- Reset  in  1  synchronous, active-high reset
- Switchs  in  WIDTH+OPW  [WIDTH-1:0] operand, [WIDTH+OPW-1:WIDTH] opcode
- Enter  in  1  level; already synchronised and debounced upstream
- Clear  in  1  level; already synchronised and debounced upstream
- A, B, Result  out  WIDTH  registered operands and result
- Operation  out  OPW  registered opcode
- Zero, CarryOut, Overflow  out  1  registered with Result
- Error  out  1  high in ERROR
- Leds  out  4  state indicator
- BcdA, BcdB, BcdResult  out  4*DIGITS  packed BCD, digit 0 in [3:0]
- BcdBusy  out  1  any converter running

## Operation
- Edge detection: EnterP = Enter & ~EnterD and ClearP = Clear & ~ClearD, where EnterD/ClearD are one-cycle delayed copies. EnterD/ClearD reset to 1, so a button held through reset yields no pulse. A held button gives exactly one pulse.
- Priority: ClearP beats EnterP in the same cycle.
- States (3-bit encoding): IDLE, WITH_A, WITH_B, COMPUTE, RESULT, ERROR.
- Leds per state: IDLE 0001, WITH_A 0011, WITH_B 0111, COMPUTE 0111, RESULT 1111, ERROR 1001.
- IDLE:
  - EnterP: A<=Switchs[WIDTH-1:0], go to WITH_A.
  - ClearP: no effect.
- WITH_A:
  - EnterP: B<=operand field, go to WITH_B.
  - ClearP: A<=0, go to IDLE.
- WITH_B:
  - EnterP: Operation<=opcode field, go to COMPUTE.
  - ClearP: A,B<=0, go to IDLE.
- COMPUTE (exactly one cycle):
  - Result and flags are registered.
  - Valid opcode goes to RESULT; invalid opcode goes to ERROR with Result=0 and all flags 0.
  - EnterP is dropped. ClearP sets a pending bit, which is executed as a Clear on the next cycle.
- RESULT:
  - EnterP (chain): A<=Result; B, Operation, Result and flags <=0; go to WITH_A.
  - ClearP: all data registers <=0, go to IDLE.
- ERROR:
  - EnterP is ignored.
  - ClearP: all data registers <=0, Error<=0, go to IDLE.
- ALU opcodes:
  - 0 ADD: {CarryOut,Result}=A+B; Overflow = signed overflow.
  - 1 SUB: Result=A-B; CarryOut=borrow (A<B); Overflow = signed overflow.
  - 2 AND, 3 OR, 4 XOR, 5 NOT A: CarryOut=Overflow=0.
  - 6 SHL A by 1: CarryOut=A[WIDTH-1].
  - 7 SHR A by 1 (logical): CarryOut=A[0].
  - 8 MUL: Result = low WIDTH bits of A*B; Overflow = upper WIDTH bits nonzero; CarryOut=0.
  - 9 to 2^OPW-1: invalid.
- Zero = (Result==0) for valid ops.
- BCD: there is one double-dabble converter per value (A, B, Result).
  - Any write to a value starts its converter on the next cycle. A write during a conversion restarts that converter.
  - Bcd* outputs hold the old digits until a conversion completes, then update atomically.
  - A write of 0 still runs a conversion.

## Timing
- Reset (sampled high at an edge): next cycle state=IDLE, Leds=0001, every other output 0, converters idle. This applies from any state, including mid-COMPUTE and mid-conversion.
- Button action latency: registers update at the first edge where Enter/Clear is sampled high.
- Result and flags are valid one cycle after the WITH_B Enter edge. RESULT or ERROR is entered at the edge after that.
- BCD latency: if a value is written at edge N, Bcd* updates at edge N+1+WIDTH. BcdBusy is high from edge N+1 through edge N+WIDTH inclusive.
- There is no backpressure: Enter pulses during BcdBusy are accepted and restart the affected converter.

## Test plan
All scenarios use WIDTH=8, DIGITS=3.
- Reset, then Enter with 200, Enter with 100, Enter with op 0 -> Result=44, CarryOut=1, Overflow=0, Zero=0, Leds=1111; BcdResult=0x044 nine cycles after Result loads.
- A=5, B=7, op 1 -> Result=254, CarryOut=1, Overflow=0; BcdResult=0x254. Then Enter in RESULT -> A=254, BcdA=0x254, state WITH_A, Result=0.
- A=20, B=13, op 8 -> Result=4, Overflow=1. A=128, B=128, op 0 -> Result=0, Zero=1, CarryOut=1, Overflow=1.
- Opcode 12 -> Error=1, Leds=1001. Five further Enter presses change nothing. Clear -> IDLE, all outputs 0, Leds=0001.
- Enter held high for 10 cycles in IDLE -> exactly one transition to WITH_A. Enter held through Reset release -> no transition.
- Enter and Clear rising together in WITH_B -> IDLE, A=B=0.
- Clear pulse during COMPUTE -> IDLE one cycle after RESULT/ERROR is entered.
- Reset asserted four cycles into a BCD conversion -> next cycle all Bcd* outputs 0 and BcdBusy=0.
